// File: rtl/noc_pkg.sv
// Shared NoC router parameters, port indices and arbiter state encoding.
// Imported by the output-port arbiter and its round-robin picker.
package noc_pkg;

    localparam int NUM_REQ      = 5;
    localparam int BUFFER_DEPTH = 4;
    localparam int CREDIT_W     = $clog2(BUFFER_DEPTH + 1);
    localparam int PTR_W        = $clog2(NUM_REQ);

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker
    import noc_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    localparam logic [PTR_W:0] NREQ = (PTR_W + 1)'(NUM_REQ);

    always_comb begin
        logic [PTR_W:0] cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!valid && req_vec[cand[PTR_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PTR_W-1:0];
            end
        end
        if (valid) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/credit_arbiter.sv
// NoC output-port arbiter: round-robin packet-locked grant with
// downstream credit tracking gating one flit per cycle.
module credit_arbiter
    import noc_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                credit_in,
    input  logic [NUM_REQ-1:0]  req_vec,
    input  logic                tail_in,
    output logic [NUM_REQ-1:0]  grant_vec,
    output logic                xfer_en,
    output logic [CREDIT_W-1:0] credit_count
);

    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0]    LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;

    rr_picker u_picker (
        .req_vec (req_vec),
        .ptr     (ptr_q),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    assign xfer_en      = (state_q == GRANT) && (credit_q != '0);
    assign grant_vec    = grant_q;
    assign credit_count = credit_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // req_vec is ignored here so the packet keeps its lock
                if (xfer_en && tail_in) begin
                    grant_d = '0;
                    ptr_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (xfer_en && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!xfer_en && credit_in && credit_q != FULL) begin
            credit_d = credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            idx_q    <= '0;
            credit_q <= FULL;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter: reset, packet transfer, round-robin,
// credit stall, grant lock and asynchronous reset mid-packet.
module tb_credit_arbiter;

    logic       clk;
    logic       reset_n;
    logic       credit_in;
    logic [4:0] req_vec;
    logic       tail_in;
    logic [4:0] grant_vec;
    logic       xfer_en;
    logic [2:0] credit_count;

    int errors = 0;
    int checks = 0;

    credit_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .credit_in    (credit_in),
        .req_vec      (req_vec),
        .tail_in      (tail_in),
        .grant_vec    (grant_vec),
        .xfer_en      (xfer_en),
        .credit_count (credit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input int n);
        credit_in = 1'b1;
        repeat (n) step();
        credit_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        credit_in = 1'b0;
        req_vec   = '0;
        tail_in   = 1'b0;
        repeat (2) step();
        checks++;
        if (grant_vec !== 5'b00000) begin
            errors++;
            $display("FAIL reset_grant: got %b want 00000", grant_vec);
        end
        checks++;
        if (credit_count !== 3'd4) begin
            errors++;
            $display("FAIL reset_credit: got %0d want 4", credit_count);
        end
        checks++;
        if (xfer_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_xfer: got %b want 0", xfer_en);
        end
        reset_n = 1'b1;
        step();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        checks++;
        if (credit_count !== 3'd4) begin
            errors++;
            $display("FAIL credit_saturate: got %0d want 4", credit_count);
        end
    endtask

    task automatic test_packet();
        logic [2:0] exp_cnt;
        req_vec = 5'b00100;
        step();
        checks++;
        if (grant_vec !== 5'b00100) begin
            errors++;
            $display("FAIL pkt_grant: got %b want 00100", grant_vec);
        end
        req_vec = '0;
        for (int i = 0; i < 3; i++) begin
            tail_in = (i == 2);
            checks++;
            if (xfer_en !== 1'b1) begin
                errors++;
                $display("FAIL pkt_xfer%0d: got %b want 1", i, xfer_en);
            end
            step();
            exp_cnt = 3'(3 - i);
            checks++;
            if (credit_count !== exp_cnt) begin
                errors++;
                $display("FAIL pkt_cnt%0d: got %0d want %0d",
                         i, credit_count, exp_cnt);
            end
        end
        tail_in = 1'b0;
        checks++;
        if (grant_vec !== 5'b00000 || xfer_en !== 1'b0) begin
            errors++;
            $display("FAIL pkt_release: got %b/%b want 00000/0",
                     grant_vec, xfer_en);
        end
        refill(3);
        checks++;
        if (credit_count !== 3'd4) begin
            errors++;
            $display("FAIL pkt_refill: got %0d want 4", credit_count);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp [6];
        exp = '{5'b00001, 5'b00010, 5'b00100,
                5'b01000, 5'b10000, 5'b00001};
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        req_vec   = 5'b11111;
        tail_in   = 1'b1;
        credit_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (grant_vec !== exp[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b",
                         i, grant_vec, exp[i]);
            end
            step();
            checks++;
            if (grant_vec !== 5'b00000) begin
                errors++;
                $display("FAIL rr_idle%0d: got %b want 00000", i, grant_vec);
            end
        end
        req_vec   = '0;
        tail_in   = 1'b0;
        credit_in = 1'b0;
        checks++;
        if (credit_count !== 3'd4) begin
            errors++;
            $display("FAIL rr_credit: got %0d want 4", credit_count);
        end
    endtask

    task automatic test_credit_stall();
        req_vec = 5'b00001;
        step();
        req_vec = '0;
        repeat (4) step();
        checks++;
        if (credit_count !== 3'd0 || xfer_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: got %0d/%b want 0/0",
                     credit_count, xfer_en);
        end
        tail_in = 1'b1;
        step();
        tail_in = 1'b0;
        checks++;
        if (grant_vec !== 5'b00001) begin
            errors++;
            $display("FAIL stall_hold: got %b want 00001", grant_vec);
        end
        credit_in = 1'b1;
        step();
        checks++;
        if (credit_count !== 3'd1 || xfer_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_return: got %0d/%b want 1/1",
                     credit_count, xfer_en);
        end
        step();
        credit_in = 1'b0;
        checks++;
        if (credit_count !== 3'd1) begin
            errors++;
            $display("FAIL stall_swap: got %0d want 1", credit_count);
        end
        tail_in = 1'b1;
        step();
        tail_in = 1'b0;
        checks++;
        if (credit_count !== 3'd0 || grant_vec !== 5'b00000) begin
            errors++;
            $display("FAIL stall_end: got %0d/%b want 0/00000",
                     credit_count, grant_vec);
        end
        refill(4);
    endtask

    task automatic test_lock();
        req_vec = 5'b00010;
        step();
        checks++;
        if (grant_vec !== 5'b00010) begin
            errors++;
            $display("FAIL lock_grant: got %b want 00010", grant_vec);
        end
        req_vec = 5'b01000;
        repeat (2) begin
            step();
            checks++;
            if (grant_vec !== 5'b00010) begin
                errors++;
                $display("FAIL lock_hold: got %b want 00010", grant_vec);
            end
        end
        tail_in = 1'b1;
        step();
        tail_in = 1'b0;
        checks++;
        if (grant_vec !== 5'b00000) begin
            errors++;
            $display("FAIL lock_idle: got %b want 00000", grant_vec);
        end
        step();
        req_vec = '0;
        checks++;
        if (grant_vec !== 5'b01000) begin
            errors++;
            $display("FAIL lock_next: got %b want 01000", grant_vec);
        end
        tail_in = 1'b1;
        step();
        tail_in = 1'b0;
        refill(4);
    endtask

    task automatic test_async_reset();
        req_vec = 5'b00001;
        step();
        req_vec = '0;
        step();
        checks++;
        if (grant_vec !== 5'b00001 || credit_count !== 3'd3) begin
            errors++;
            $display("FAIL arst_pre: got %b/%0d want 00001/3",
                     grant_vec, credit_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant_vec !== 5'b00000 || credit_count !== 3'd4 ||
            xfer_en !== 1'b0) begin
            errors++;
            $display("FAIL arst_mid: got %b/%0d/%b want 00000/4/0",
                     grant_vec, credit_count, xfer_en);
        end
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_round_robin();
        test_credit_stall();
        test_lock();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
